adc_stream_packer: RTL and testbench
====================================

ADC_STREAM_PACKER -- requirements
Module: adc_stream_packer

Interface
REQ-001 SHALL have parameter SAMPLES_PER_FRAME, default 100000, expected samples per capture frame (1..2^20-1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output word FIFO depth (power of two, >=4).
REQ-003 i_CMOS_Clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_Reset  in  1  asynchronous, active-high reset.
REQ-005 i_Start  in  1  capture request, sampled in IDLE only.
REQ-006 o_ADC_Work  out  1  work request to ADC producer.
REQ-007 i_ADC_Data  in  12  sample from producer.
REQ-008 i_ADC_Valid  in  1  i_ADC_Data valid this cycle.
REQ-009 i_ADC_Last  in  1  final sample of frame, qualified by i_ADC_Valid.
REQ-010 i_ADC_Done  in  1  producer frame-complete level.
REQ-011 m_axis_tdata  out  32  packed output word.
REQ-012 m_axis_tvalid  out  1  output word valid.
REQ-013 m_axis_tready  in  1  downstream ready.
REQ-014 m_axis_tlast  out  1  last word of frame.
REQ-015 o_Busy  out  1  high in any state except IDLE.
REQ-016 o_Overflow  out  1  sticky: a word was dropped this frame.
REQ-017 o_Frame_Done  out  1  one-cycle pulse when frame fully drained.

Function
REQ-018 FSM states SHALL be IDLE, CAPTURE, DRAIN, RELEASE.
REQ-019 IDLE -> CAPTURE when i_Start=1; on that edge o_ADC_Work<=1, o_Overflow<=0, sample counter and packer cleared.
REQ-020 CAPTURE: each cycle with i_ADC_Valid=1 SHALL consume one sample and increment 20-bit sample counter.
REQ-021 Packing: first sample of a pair -> bits [11:0], second -> bits [27:16]; bits [15:12] and [31:28] zero.
REQ-022 Word SHALL be pushed into FIFO on the cycle its second sample is consumed (1-cycle latency to FIFO write).
REQ-023 Frame end = i_ADC_Valid & i_ADC_Last, or sample counter reaching SAMPLES_PER_FRAME on a valid sample, whichever first.
REQ-024 At frame end with odd sample count, SHALL push word with upper half zero; pushed word carries tlast=1.
REQ-025 At frame end, o_ADC_Work<=0 and CAPTURE -> DRAIN; samples after frame end SHALL be ignored.
REQ-026 If i_ADC_Done=1 in CAPTURE before frame end, SHALL treat as frame end (flush partial word with tlast).
REQ-027 FIFO full on push: word SHALL be dropped, o_Overflow<=1; if dropped word had tlast, tlast SHALL be forced on the most recent stored word (no tlast-less frame).
REQ-028 FIFO push and pop same cycle SHALL be allowed when full or empty-with-bypass-disabled (no bypass; min FIFO latency 1 cycle).
REQ-029 AXI-Stream: tdata/tlast SHALL hold stable while tvalid=1 & tready=0; transfer on tvalid & tready.
REQ-030 m_axis_tvalid = FIFO not empty; driven from register/FIFO output, not combinationally from i_ADC_*.
REQ-031 DRAIN -> RELEASE when tlast word transferred; o_Frame_Done pulses that cycle+1.
REQ-032 RELEASE -> IDLE when i_ADC_Done=0 (producer handshake complete); i_Start ignored until IDLE.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH with extra bit for full/empty.

Reset
REQ-034 While i_Reset=1: state IDLE, o_ADC_Work=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, o_Busy=0, o_Overflow=0, o_Frame_Done=0, FIFO empty, counters 0.
REQ-035 Reset mid-frame SHALL discard FIFO contents and partial word; no tlast emitted.

Verification
REQ-036 Start, 4 valid samples 0x001..0x004, Last on 4th, tready=1 -> words 0x00020001, 0x00040003(tlast), o_Frame_Done pulse, Work drops after frame end.
REQ-037 3 samples 0xABC,0x123,0xFFF with Last on 3rd -> 0x01230ABC, 0x00000FFF with tlast.
REQ-038 SAMPLES_PER_FRAME=6, no Last, 8 valid samples -> 3 words, tlast on 3rd, samples 7-8 ignored.
REQ-039 tready=0 for 40 sample pairs, FIFO_DEPTH=16 -> 16 words held, o_Overflow=1, tlast forced on last stored word, tdata stable while stalled.
REQ-040 Assert i_Reset after 5 samples -> all outputs 0 next edge, tvalid low, FSM IDLE, new Start captures cleanly.
REQ-041 i_ADC_Done held high after frame -> FSM waits in RELEASE, o_Busy=1; Done low -> IDLE next cycle.

Source files
------------

// File: rtl/adc_stream_packer.sv
// Packs 12-bit ADC samples in pairs into 32-bit AXI-Stream words through a small FIFO.
// A frame ends on Last, on the sample-count limit, or on an early producer Done.
module adc_stream_packer #(
    parameter int unsigned SAMPLES_PER_FRAME = 100000,
    parameter int unsigned FIFO_DEPTH        = 16
) (
    input  logic        i_CMOS_Clk,
    input  logic        i_Reset,
    input  logic        i_Start,
    output logic        o_ADC_Work,
    input  logic [11:0] i_ADC_Data,
    input  logic        i_ADC_Valid,
    input  logic        i_ADC_Last,
    input  logic        i_ADC_Done,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        o_Busy,
    output logic        o_Overflow,
    output logic        o_Frame_Done
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [19:0] SpfCount = 20'(SAMPLES_PER_FRAME);
    localparam logic [AW:0] PtrOne   = (AW + 1)'(1);
    localparam logic [AW-1:0] IdxOne = AW'(1);

    typedef enum logic [1:0] {StIdle, StCapture, StDrain, StRelease} state_e;

    state_e      state_q, state_d;
    logic [19:0] count_q, count_d, count_inc;
    logic [11:0] low_q, low_d;
    logic        work_q, work_d;
    logic        ovf_q;
    logic        done_pulse_q, done_pulse_d;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [32:0] mem_q [FIFO_DEPTH];

    logic [AW-1:0] wr_idx, rd_idx, wr_prev_idx;
    logic          push, push_last, pop, full, empty, push_ok, drop, frame_end, start_frame;
    logic [31:0]   push_data;
    logic [32:0]   head;

    assign wr_idx      = wr_ptr_q[AW-1:0];
    assign rd_idx      = rd_ptr_q[AW-1:0];
    assign wr_prev_idx = wr_idx - IdxOne;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign head        = mem_q[rd_idx];

    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? 32'h0 : head[31:0];
    assign m_axis_tlast  = !empty && head[32];
    assign pop           = m_axis_tvalid && m_axis_tready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok       = push && (!full || pop);
    assign drop          = push && full && !pop;
    assign count_inc     = count_q + 20'd1;
    assign start_frame   = (state_q == StIdle) && i_Start;

    assign o_ADC_Work   = work_q;
    assign o_Busy       = (state_q != StIdle);
    assign o_Overflow   = ovf_q;
    assign o_Frame_Done = done_pulse_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        low_d        = low_q;
        work_d       = work_q;
        done_pulse_d = 1'b0;
        push         = 1'b0;
        push_last    = 1'b0;
        push_data    = 32'h0;
        frame_end    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_Start) begin
                    state_d = StCapture;
                    work_d  = 1'b1;
                    count_d = 20'h0;
                    low_d   = 12'h0;
                end
            end
            StCapture: begin
                frame_end = i_ADC_Done ||
                            (i_ADC_Valid && (i_ADC_Last || (count_inc == SpfCount)));
                if (i_ADC_Valid) begin
                    count_d = count_inc;
                    if (count_q[0]) begin
                        push      = 1'b1;
                        push_data = {4'h0, i_ADC_Data, 4'h0, low_q};
                    end else begin
                        low_d = i_ADC_Data;
                        if (frame_end) begin
                            push      = 1'b1;
                            push_data = {20'h0, i_ADC_Data};
                        end
                    end
                end else if (frame_end) begin
                    // Early Done: flush the pending half, or an empty word so tlast exists.
                    push      = 1'b1;
                    push_data = count_q[0] ? {20'h0, low_q} : 32'h0;
                end
                if (frame_end) begin
                    push_last = 1'b1;
                    work_d    = 1'b0;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                if (pop && head[32]) begin
                    state_d      = StRelease;
                    done_pulse_d = 1'b1;
                end
            end
            StRelease: begin
                if (!i_ADC_Done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_CMOS_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= StIdle;
            count_q      <= 20'h0;
            low_q        <= 12'h0;
            work_q       <= 1'b0;
            ovf_q        <= 1'b0;
            done_pulse_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            low_q        <= low_d;
            work_q       <= work_d;
            done_pulse_q <= done_pulse_d;
            if (start_frame)  ovf_q <= 1'b0;
            else if (drop)    ovf_q <= 1'b1;
            if (push_ok)      wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)          rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge i_CMOS_Clk) begin
        if (push_ok) begin
            mem_q[wr_idx] <= {push_last, push_data};
        end else if (drop && push_last) begin
            mem_q[wr_prev_idx][32] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_stream_packer.sv
// Randomized self-checking bench for adc_stream_packer against a frame-level packing model.
module tb_adc_stream_packer;

    localparam int unsigned SPF   = 100;
    localparam int unsigned SPF_S = 6;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, start, valid, last, done, tready;
    logic [11:0] data;

    logic        work, tvalid, tlast, busy, ovf, fd;
    logic [31:0] tdata;
    logic        s_work, s_tvalid, s_tlast, s_busy, s_ovf, s_fd;
    logic [31:0] s_tdata;

    always #5 clk = ~clk;

    adc_stream_packer #(.SAMPLES_PER_FRAME(SPF), .FIFO_DEPTH(DEPTH)) dut (
        .i_CMOS_Clk(clk), .i_Reset(rst), .i_Start(start), .o_ADC_Work(work),
        .i_ADC_Data(data), .i_ADC_Valid(valid), .i_ADC_Last(last), .i_ADC_Done(done),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .o_Busy(busy), .o_Overflow(ovf), .o_Frame_Done(fd)
    );

    adc_stream_packer #(.SAMPLES_PER_FRAME(SPF_S), .FIFO_DEPTH(DEPTH)) dut_s (
        .i_CMOS_Clk(clk), .i_Reset(rst), .i_Start(start), .o_ADC_Work(s_work),
        .i_ADC_Data(data), .i_ADC_Valid(valid), .i_ADC_Last(last), .i_ADC_Done(done),
        .m_axis_tdata(s_tdata), .m_axis_tvalid(s_tvalid), .m_axis_tready(tready),
        .m_axis_tlast(s_tlast), .o_Busy(s_busy), .o_Overflow(s_ovf), .o_Frame_Done(s_fd)
    );

    int          checks = 0, errors = 0;
    int          fd_cnt = 0, fd_s_cnt = 0, stall_err = 0;
    bit          rand_ready = 1'b0;
    logic        stall_prev = 1'b0;
    logic [32:0] stall_word = '0;
    logic [11:0] smp[$];
    logic [32:0] exp_q[$], got_q[$], got_s_q[$];

    // Transfers, Frame_Done pulses and stall stability are observed on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (tvalid && tready)   got_q.push_back({tlast, tdata});
            if (s_tvalid && tready) got_s_q.push_back({s_tlast, s_tdata});
            if (fd)   fd_cnt++;
            if (s_fd) fd_s_cnt++;
            if (stall_prev && (!tvalid || ({tlast, tdata} != stall_word))) stall_err++;
            stall_prev = tvalid && !tready;
            stall_word = {tlast, tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) tready = ($urandom_range(0, 3) != 0);
    endtask

    // Expected words for a frame whose first 'consumed' samples of smp were taken.
    task automatic model(input int consumed);
        logic [11:0] hi;
        exp_q.delete();
        for (int k = 0; 2 * k < consumed; k++) begin
            hi = (2 * k + 1 < consumed) ? smp[2 * k + 1] : 12'h0;
            exp_q.push_back({(2 * k + 2 >= consumed), 4'h0, hi, 4'h0, smp[2 * k]});
        end
    endtask

    task automatic fill(input int n);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(12'($urandom));
    endtask

    task automatic begin_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int n, input int last_idx, input bit gaps);
        for (int i = 0; i < n; i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                valid = 1'b0;
                tick();
            end
            valid = 1'b1;
            data  = smp[i];
            last  = (i == last_idx);
            tick();
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic wait_frame(input bit use_s, input int base, input string name);
        int n;
        n = 0;
        while (((use_s ? fd_s_cnt : fd_cnt) == base) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if ((use_s ? fd_s_cnt : fd_cnt) == base) begin
            errors++;
            $display("FAIL %s frame_done: got no pulse, expected one within 3000 cycles", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: got busy=%b, expected 0", name, busy);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; done = 1'b0; data = '0;
        tready = 1'b1; rand_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        got_q.delete();
        got_s_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; done = 1'b0; data = '0;
        tready = 1'b1;
        tick();
        tick();
        checks++;
        if ({work, tvalid, tlast, tdata, busy, ovf, fd, s_tvalid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {work, tvalid, tlast, tdata, busy, ovf, fd, s_tvalid});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int base;
        smp = '{12'h001, 12'h002, 12'h003, 12'h004};
        got_q.delete();
        base = fd_cnt;
        begin_frame();
        checks++;
        if (work !== 1'b1) begin
            errors++;
            $display("FAIL basic work_rise: got %b, expected 1", work);
        end
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; data = smp[i]; last = (i == 3);
            tick();
            if (i == 0) begin
                checks++;
                if (tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic half_word: got tvalid=%b, expected 0", tvalid);
                end
            end
            if (i == 1) begin
                checks++;
                if ({tvalid, tdata} !== {1'b1, 32'h00020001}) begin
                    errors++;
                    $display("FAIL basic first_word: got %b/%h, expected 1/00020001",
                             tvalid, tdata);
                end
            end
        end
        valid = 1'b0; last = 1'b0;
        checks++;
        if (work !== 1'b0) begin
            errors++;
            $display("FAIL basic work_fall: got %b, expected 0", work);
        end
        wait_frame(1'b0, base, "basic");
        wait_idle("basic");
        tick();
        model(4);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic count: got %0d words, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic word%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (fd_cnt - base != 1) begin
            errors++;
            $display("FAIL basic pulse_width: got %0d cycles, expected 1", fd_cnt - base);
        end
    endtask

    task automatic test_odd();
        int base;
        smp = '{12'hABC, 12'h123, 12'hFFF};
        got_q.delete();
        base = fd_cnt;
        begin_frame();
        send(3, 2, 1'b1);
        wait_frame(1'b0, base, "odd");
        wait_idle("odd");
        model(3);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== {1'b0, 32'h01230ABC} ||
            got_q[1] !== {1'b1, 32'h00000FFF}) begin
            errors++;
            $display("FAIL odd words: got %p, expected %p", got_q, exp_q);
        end
    endtask

    task automatic test_random();
        int base, n, li;
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            n  = $urandom_range(1, 30);
            li = $urandom_range(0, n - 1);
            fill(n);
            wait_idle("random_pre");
            got_q.delete();
            base = fd_cnt;
            begin_frame();
            send(n, li, 1'b1);
            wait_frame(1'b0, base, "random");
            wait_idle("random");
            model(li + 1);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL random f%0d count: got %0d, expected %0d", f, got_q.size(),
                         exp_q.size());
            end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random f%0d word%0d: got %h, expected %h", f, i, got_q[i],
                             exp_q[i]);
                end
            end
            checks++;
            if (ovf !== 1'b0) begin
                errors++;
                $display("FAIL random f%0d overflow: got %b, expected 0", f, ovf);
            end
        end
        rand_ready = 1'b0;
        tready = 1'b1;
    endtask

    task automatic test_overflow();
        int base;
        fill(80);
        wait_idle("overflow_pre");
        tready = 1'b0;
        got_q.delete();
        base = fd_cnt;
        stall_err = 0;
        begin_frame();
        send(80, 79, 1'b0);
        model(32);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if ({busy, tvalid, ovf, tdata} !== {3'b111, exp_q[0][31:0]}) begin
            errors++;
            $display("FAIL overflow stalled: got busy/tvalid/ovf=%b%b%b data %h, expected 111 %h",
                     busy, tvalid, ovf, tdata, exp_q[0][31:0]);
        end
        tready = 1'b1;
        wait_frame(1'b0, base, "overflow");
        wait_idle("overflow");
        checks++;
        if (got_q.size() != DEPTH) begin
            errors++;
            $display("FAIL overflow count: got %0d words, expected %0d", got_q.size(), DEPTH);
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL overflow word%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_err != 0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow stability: got %0d unstable cycles ovf=%b, expected 0 and 1",
                     stall_err, ovf);
        end
    endtask

    task automatic test_release();
        int base;
        fill(4);
        got_q.delete();
        base = fd_cnt;
        begin_frame();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL release ovf_clear: got %b, expected 0", ovf);
        end
        send(4, 3, 1'b1);
        done = 1'b1;
        wait_frame(1'b0, base, "release");
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL release hold: got busy=%b, expected 1", busy);
        end
        done = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL release exit: got busy=%b, expected 0", busy);
        end
        model(4);
        checks++;
        if (got_q != exp_q) begin
            errors++;
            $display("FAIL release words: got %p, expected %p", got_q, exp_q);
        end
    endtask

    task automatic test_done_early();
        int base;
        fill(3);
        wait_idle("done_early_pre");
        got_q.delete();
        base = fd_cnt;
        begin_frame();
        send(3, -1, 1'b1);
        done = 1'b1;
        tick();
        checks++;
        if (work !== 1'b0) begin
            errors++;
            $display("FAIL done_early work: got %b, expected 0", work);
        end
        wait_frame(1'b0, base, "done_early");
        done = 1'b0;
        wait_idle("done_early");
        model(3);
        checks++;
        if (got_q != exp_q) begin
            errors++;
            $display("FAIL done_early words: got %p, expected %p", got_q, exp_q);
        end
    endtask

    task automatic test_reset_mid();
        int base, lasts;
        fill(5);
        tready = 1'b1;
        got_q.delete();
        begin_frame();
        send(5, -1, 1'b0);
        rst = 1'b1;
        tick();
        checks++;
        if ({work, tvalid, tlast, tdata, busy, ovf, fd} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: got %h, expected 0",
                     {work, tvalid, tlast, tdata, busy, ovf, fd});
        end
        rst = 1'b0;
        tick();
        tick();
        lasts = 0;
        foreach (got_q[i]) if (got_q[i][32]) lasts++;
        checks++;
        if (lasts != 0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid tlast: got %0d tlast words tvalid=%b, expected 0 and 0",
                     lasts, tvalid);
        end
        fill(4);
        got_q.delete();
        base = fd_cnt;
        begin_frame();
        send(4, 3, 1'b1);
        wait_frame(1'b0, base, "reset_mid");
        wait_idle("reset_mid");
        model(4);
        checks++;
        if (got_q != exp_q) begin
            errors++;
            $display("FAIL reset_mid words: got %p, expected %p", got_q, exp_q);
        end
    endtask

    task automatic test_spf_limit();
        int base;
        do_reset();
        fill(8);
        base = fd_s_cnt;
        begin_frame();
        send(8, -1, 1'b0);
        wait_frame(1'b1, base, "spf_limit");
        for (int i = 0; i < 4; i++) tick();
        model(SPF_S);
        checks++;
        if (got_s_q.size() != 3) begin
            errors++;
            $display("FAIL spf_limit count: got %0d words, expected 3", got_s_q.size());
        end
        foreach (exp_q[i]) if (i < got_s_q.size()) begin
            checks++;
            if (got_s_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL spf_limit word%0d: got %h, expected %h", i, got_s_q[i], exp_q[i]);
            end
        end
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL spf_limit idle: got busy=%b, expected 0", s_busy);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd();
        test_random();
        test_overflow();
        test_release();
        test_done_early();
        test_reset_mid();
        test_spf_limit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
